if_fetch_unit: RTL and testbench

Instruction-fetch front end for the RVX pipeline. It sits at the receiving end of the jump/flush control interface. It holds the fetch PC and issues requests to instruction memory over a valid/ready handshake. It buffers returned instructions in a 2-entry queue and loads the IF/ID pipeline register. On a redirect (`jumpEnIn`) or an IF flush (`flushIFIn`) it squashes everything in flight: queued words, outstanding memory responses and the IF/ID slot.

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_fetch_fifo.sv | 58 +++++
 rtl/if_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, FSM state type and FIFO entry layout for the RVX fetch front end.
package if_fetch_unit_pkg;

   localparam int unsigned BUS_W    = 32;
   localparam int unsigned RVINST_W = 32;

   // Outstanding/discard counters are one bit wider than the 0..2 live range:
   // stale responses still owed after a kill stack on top of new requests.
   localparam int unsigned CNT_W = 3;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HOLD = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [BUS_W-1:0]    pc;
      logic [RVINST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, inst} queue between instruction memory and the IF/ID register.
// Head is always slot 0; a pop shifts slot 1 down. Clear wins over push/pop.
module if_fetch_fifo
   import if_fetch_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   input  logic                i_push,
   input  logic [BUS_W-1:0]    i_push_pc,
   input  logic [RVINST_W-1:0] i_push_inst,
   input  logic                i_pop,
   output logic [1:0]          o_count,
   output logic [BUS_W-1:0]    o_head_pc,
   output logic [RVINST_W-1:0] o_head_inst
);

   fetch_entry_t r_mem [2];
   logic [1:0]   r_count;
   fetch_entry_t w_in;

   assign w_in        = {i_push_pc, i_push_inst};
   assign o_count     = r_count;
   assign o_head_pc   = r_mem[0].pc;
   assign o_head_inst = r_mem[0].inst;

   // Storage and occupancy; a full queue popping in the same cycle accepts the push.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count  <= '0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               r_mem[r_count[0]] <= w_in;
               r_count           <= r_count + 2'd1;
            end
            2'b01: begin
               r_mem[0] <= r_mem[1];
               r_count  <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_mem[0] <= r_mem[1];
                  r_mem[1] <= w_in;
               end else begin
                  r_mem[0] <= w_in;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// RVX instruction-fetch front end: fetch PC, imem valid/ready requests,
// response buffering and the IF/ID register, with squash on jump or IF flush.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [BUS_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                jumpEnIn,
   input  logic [BUS_W-1:0]    jumpAddrIn,
   input  logic                flushIFIn,
   input  logic                stallIn,
   output logic                imemReqValidOut,
   input  logic                imemReqReadyIn,
   output logic [BUS_W-1:0]    imemReqAddrOut,
   input  logic                imemRespValidIn,
   input  logic [RVINST_W-1:0] imemRespDataIn,
   output logic                validOut_IFID,
   output logic [RVINST_W-1:0] instOut_IFID,
   output logic [BUS_W-1:0]    pcOut_IFID
);

   fetch_state_e        r_state, w_state_next;
   logic [BUS_W-1:0]    r_fetch_pc;
   logic [CNT_W-1:0]    r_inflight, r_discard;
   logic [CNT_W-1:0]    w_inflight_next, w_discard_next;
   logic [CNT_W-1:0]    w_live_out, w_occupancy;
   logic [BUS_W-1:0]    r_tag [2];
   logic                r_valid;
   logic [RVINST_W-1:0] r_inst;
   logic [BUS_W-1:0]    r_pc;

   logic                w_kill, w_req_valid, w_accept, w_push, w_pop;
   logic [BUS_W-1:0]    w_jump_pc;
   logic [1:0]          w_fifo_count;
   logic [BUS_W-1:0]    w_head_pc;
   logic [RVINST_W-1:0] w_head_inst;

   assign w_kill      = jumpEnIn | flushIFIn;
   assign w_jump_pc   = jumpAddrIn & ~BUS_W'(3);
   // Outstanding requests whose responses will actually be kept.
   assign w_live_out  = r_inflight - r_discard;
   assign w_occupancy = w_live_out + CNT_W'(w_fifo_count);
   assign w_accept    = w_req_valid & imemReqReadyIn;
   assign w_push      = imemRespValidIn & ~w_kill & (r_discard == '0);
   assign w_pop       = ~w_kill & ~stallIn & (w_fifo_count != 2'd0);

   assign imemReqValidOut = w_req_valid;
   assign imemReqAddrOut  = r_fetch_pc;
   assign validOut_IFID   = r_valid;
   assign instOut_IFID    = r_inst;
   assign pcOut_IFID      = r_pc;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= FS_RUN;
      else      r_state <= w_state_next;
   end

   // Next state and request issue; saturation guard only matters under repeated kills.
   always_comb begin
      w_state_next = r_state;
      w_req_valid  = 1'b0;
      case (r_state)
         FS_RUN: begin
            if (flushIFIn && !jumpEnIn) w_state_next = FS_HOLD;
            w_req_valid = rst && !w_kill && (w_occupancy < CNT_W'(2)) && (r_inflight != '1);
         end
         FS_HOLD: w_state_next = FS_RUN;
         default: w_state_next = FS_RUN;
      endcase
   end

   // Accept/response accounting; a kill marks every still-owed response for discard.
   always_comb begin
      w_inflight_next = r_inflight + CNT_W'(w_accept) - CNT_W'(imemRespValidIn);
      w_discard_next  = r_discard;
      if (w_kill)
         w_discard_next = w_inflight_next;
      else if (imemRespValidIn && (r_discard != '0))
         w_discard_next = r_discard - CNT_W'(1);
   end

   // Fetch PC and outstanding/discard counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_discard  <= '0;
      end else begin
         r_inflight <= w_inflight_next;
         r_discard  <= w_discard_next;
         if (jumpEnIn)      r_fetch_pc <= w_jump_pc;
         else if (w_accept) r_fetch_pc <= r_fetch_pc + BUS_W'(4);
      end
   end

   // PC tags of live requests only; tags of discarded requests are never consumed,
   // so the depth-2 queue effectively empties when a kill zeroes the live count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tag[0] <= '0;
         r_tag[1] <= '0;
      end else if (w_push && w_accept) begin
         if (w_live_out == CNT_W'(1)) begin
            r_tag[0] <= r_fetch_pc;
         end else begin
            r_tag[0] <= r_tag[1];
            r_tag[1] <= r_fetch_pc;
         end
      end else if (w_push) begin
         r_tag[0] <= r_tag[1];
      end else if (w_accept) begin
         r_tag[w_live_out[0]] <= r_fetch_pc;
      end
   end

   if_fetch_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_kill),
      .i_push     (w_push),
      .i_push_pc  (r_tag[0]),
      .i_push_inst(imemRespDataIn),
      .i_pop      (w_pop),
      .o_count    (w_fifo_count),
      .o_head_pc  (w_head_pc),
      .o_head_inst(w_head_inst)
   );

   // IF/ID register: kill beats stall; an empty queue loads a bubble.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
         r_pc    <= '0;
      end else if (w_kill) begin
         r_valid <= 1'b0;
      end else if (!stallIn) begin
         r_valid <= w_pop;
         if (w_pop) begin
            r_inst <= w_head_inst;
            r_pc   <= w_head_pc;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a latency-programmable memory model answers
// requests, an address model checks every accepted request, and a scoreboard of
// expected PCs is compared whenever decode consumes a valid IF/ID slot.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst = 1'b0;
   logic                jumpEnIn = 1'b0;
   logic [BUS_W-1:0]    jumpAddrIn = '0;
   logic                flushIFIn = 1'b0;
   logic                stallIn = 1'b0;
   logic                imemReqValidOut;
   logic                imemReqReadyIn = 1'b0;
   logic [BUS_W-1:0]    imemReqAddrOut;
   logic                imemRespValidIn = 1'b0;
   logic [RVINST_W-1:0] imemRespDataIn = '0;
   logic                validOut_IFID;
   logic [RVINST_W-1:0] instOut_IFID;
   logic [BUS_W-1:0]    pcOut_IFID;

   logic                w2_rv, w2_vo;
   logic [BUS_W-1:0]    w2_ra, w2_pc;
   logic [RVINST_W-1:0] w2_inst;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .jumpEnIn(jumpEnIn), .jumpAddrIn(jumpAddrIn),
      .flushIFIn(flushIFIn), .stallIn(stallIn),
      .imemReqValidOut(imemReqValidOut), .imemReqReadyIn(imemReqReadyIn),
      .imemReqAddrOut(imemReqAddrOut), .imemRespValidIn(imemRespValidIn),
      .imemRespDataIn(imemRespDataIn), .validOut_IFID(validOut_IFID),
      .instOut_IFID(instOut_IFID), .pcOut_IFID(pcOut_IFID)
   );

   // Second instance only exercises the wrap of a top-of-memory reset PC.
   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .rst(rst), .jumpEnIn(1'b0), .jumpAddrIn(32'h0),
      .flushIFIn(1'b0), .stallIn(1'b0),
      .imemReqValidOut(w2_rv), .imemReqReadyIn(1'b1),
      .imemReqAddrOut(w2_ra), .imemRespValidIn(1'b0),
      .imemRespDataIn(32'h0), .validOut_IFID(w2_vo),
      .instOut_IFID(w2_inst), .pcOut_IFID(w2_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mem_req_t;

   mem_req_t    mem_q[$];
   logic [31:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0, last_due = 0, consumed = 0, accepts = 0;
   int unsigned g_lat = 1;
   bit          g_ready = 1'b1;
   logic [31:0] model_pc = 32'h0;
   logic        smp_rv, smp_vo, smp2_rv;
   logic [31:0] smp_ra, smp_pc, smp2_ra;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_progress(input string tag, input int unsigned c0, input int unsigned minimum);
      checks++;
      assert (consumed - c0 >= minimum) else begin
         errors++;
         $error("FAIL %s observed=%0d expected>=%0d", tag, consumed - c0, minimum);
      end
   endtask

   task automatic set_exp(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // One clock cycle: drive inputs, sample at negedge, return just after the next posedge.
   task automatic step(input logic j, input logic [31:0] ja, input logic f, input logic s);
      mem_req_t    m;
      logic [31:0] e;
      jumpEnIn       = j;
      jumpAddrIn     = ja;
      flushIFIn      = f;
      stallIn        = s;
      imemReqReadyIn = g_ready;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         imemRespValidIn = 1'b1;
         imemRespDataIn  = inst_of(m.addr);
      end else begin
         imemRespValidIn = 1'b0;
         imemRespDataIn  = $urandom;
      end
      @(negedge clk);
      smp_rv  = imemReqValidOut;
      smp_ra  = imemReqAddrOut;
      smp_vo  = validOut_IFID;
      smp_pc  = pcOut_IFID;
      smp2_rv = w2_rv;
      smp2_ra = w2_ra;
      if (validOut_IFID && !s && !j && !f) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL ifid_unexpected observed=%h expected=none", pcOut_IFID);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ifid_pc", pcOut_IFID, e);
            chk("ifid_inst", instOut_IFID, inst_of(e));
         end
         consumed++;
      end
      if (imemReqValidOut && g_ready) begin
         chk("req_addr", imemReqAddrOut, model_pc);
         m.addr   = imemReqAddrOut;
         m.due    = (cyc + g_lat > last_due) ? cyc + g_lat : last_due + 1;
         last_due = m.due;
         mem_q.push_back(m);
         model_pc = model_pc + 32'd4;
         accepts++;
      end
      if (j) model_pc = ja & ~32'd3;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      int unsigned c0, a0;
      logic [31:0] base;
      bit          hit;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, validOut_IFID}, 32'd0);
      chk("rst_inst", instOut_IFID, 32'h0);
      chk("rst_pc", pcOut_IFID, 32'h0);
      chk("rst_reqvalid", {31'b0, imemReqValidOut}, 32'd0);
      rst = 1'b1;

      // Free run from RESET_PC
      set_exp(32'h0);
      c0 = consumed;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("first_req_valid", {31'b0, smp_rv}, 32'd1);
      chk("first_req_addr", smp_ra, 32'h0);
      chk("wrap_first_addr", smp2_ra, 32'hFFFF_FFFC);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap_next_valid", {31'b0, smp2_rv}, 32'd1);
      chk("wrap_next_addr", smp2_ra, 32'h0);
      run(12);
      chk_progress("freerun_progress", c0, 4);

      // Jump with two requests in flight, 3-cycle memory
      g_lat = 3;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (mem_q.size() == 2) hit = 1'b1;
         else step(1'b0, 32'h0, 1'b0, 1'b0);
      end
      chk("jump_wait_two_inflight", {31'b0, hit}, 32'd1);
      set_exp(32'h100);
      c0 = consumed;
      step(1'b1, 32'h100, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("jump_req_valid", {31'b0, smp_rv}, 32'd1);
      chk("jump_req_addr", smp_ra, 32'h100);
      chk("jump_ifid_bubble", {31'b0, smp_vo}, 32'd0);
      run(15);
      chk_progress("jump_progress", c0, 3);

      // Flush then registered jump
      g_lat = 1;
      run(4);
      set_exp(32'h40);
      c0 = consumed;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h40, 1'b0, 1'b0);
      chk("hold_no_req", {31'b0, smp_rv}, 32'd0);
      chk("hold_ifid_invalid", {31'b0, smp_vo}, 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("flushjump_req_valid", {31'b0, smp_rv}, 32'd1);
      chk("flushjump_req_addr", smp_ra, 32'h40);
      chk("flushjump_ifid_invalid", {31'b0, smp_vo}, 32'd0);
      run(10);
      chk_progress("flushjump_progress", c0, 3);

      // Flush alone: one idle cycle, resume from the next unfetched PC
      g_lat = 2;
      run(3);
      base = model_pc;
      set_exp(base);
      c0 = consumed;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_idle", {31'b0, smp_rv}, 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_resume_valid", {31'b0, smp_rv}, 32'd1);
      chk("flush_resume_addr", smp_ra, base);
      run(12);
      chk_progress("flush_progress", c0, 3);

      // Stall for 5 cycles while memory keeps answering
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (validOut_IFID) hit = 1'b1;
         else step(1'b0, 32'h0, 1'b0, 1'b0);
      end
      chk("stall_wait_valid", {31'b0, hit}, 32'd1);
      a0 = accepts;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1);
         chk("stall_hold_valid", {31'b0, smp_vo}, 32'd1);
         chk("stall_hold_pc", smp_pc, (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF);
         chk("stall_outstanding_le2", {31'b0, mem_q.size() <= 2}, 32'd1);
      end
      chk("stall_accepts_le2", {31'b0, (accepts - a0) <= 2}, 32'd1);
      c0 = consumed;
      run(12);
      chk_progress("stall_release_progress", c0, 4);

      // Jump and flush together: jump wins, no idle cycle
      set_exp(32'h200);
      c0 = consumed;
      step(1'b1, 32'h200, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("jumpflush_req_valid", {31'b0, smp_rv}, 32'd1);
      chk("jumpflush_req_addr", smp_ra, 32'h200);
      run(8);
      chk_progress("jumpflush_progress", c0, 2);

      // Misaligned target with a response arriving in the kill cycle
      g_lat = 1;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) hit = 1'b1;
         else step(1'b0, 32'h0, 1'b0, 1'b0);
      end
      chk("killresp_wait", {31'b0, hit}, 32'd1);
      set_exp(32'h100);
      c0 = consumed;
      step(1'b1, 32'h103, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("misalign_req_valid", {31'b0, smp_rv}, 32'd1);
      chk("misalign_req_addr", smp_ra, 32'h100);
      run(10);
      chk_progress("killresp_progress", c0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
